// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Sequential front-end for the 8-bit combinational ALU. Tagged commands are
// queued in a small FIFO, issued to the ALU one at a time, and answered with
// one tagged response each, strictly in command order.
//
// Handshakes (both interfaces): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge. The consumer may raise or lower ready freely.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready = FIFO not full)
//   cmd_sel/a/b/tag          command payload (ALU opcode, operands, tag)
//   alu_a/alu_b/alu_sel      registered operands driven into the ALU
//   alu_out/alu_cout         combinational ALU result and carry of a+b
//   rsp_valid/rsp_ready      response handshake
//   rsp_result/cout/err/tag  response payload
//   ops_done                 wrapping count of completed response handshakes
//   dbg_state                current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// DEPTH must be a power of two and at least 2; the pointers rely on natural
// binary wrap.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_sel,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] ops_done,
  output logic [1:0]       dbg_state
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] OPS_ONE  = CNT_W'(1);

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_DIV = 3'b011;

  typedef struct packed {
    logic [2:0]       sel;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // FIFO storage carries no reset: occupancy alone decides what is valid.
  cmd_t mem_q [DEPTH];

  state_t           state_q,      state_d;
  logic [PTR_W-1:0] wr_ptr_q,     wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,     rd_ptr_d;
  logic [OCC_W-1:0] occ_q,        occ_d;
  logic [7:0]       alu_a_q,      alu_a_d;
  logic [7:0]       alu_b_q,      alu_b_d;
  logic [2:0]       alu_sel_q,    alu_sel_d;
  logic [TAG_W-1:0] tag_q,        tag_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic [7:0]       rsp_result_q, rsp_result_d;
  logic             rsp_cout_q,   rsp_cout_d;
  logic             rsp_err_q,    rsp_err_d;
  logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;
  logic [CNT_W-1:0] ops_done_q,   ops_done_d;

  cmd_t cmd_in;
  cmd_t head;
  logic push;
  logic pop;
  logic rsp_fire;
  logic div_zero;

  assign cmd_ready = (occ_q != OCC_FULL);

  always_comb begin
    cmd_in.sel = cmd_sel;
    cmd_in.a   = cmd_a;
    cmd_in.b   = cmd_b;
    cmd_in.tag = cmd_tag;
    head       = mem_q[rd_ptr_q];

    push     = cmd_valid && cmd_ready;
    pop      = (state_q == ST_IDLE) && (occ_q != '0);
    rsp_fire = rsp_valid_q && rsp_ready;
    // The issued operands stay registered through EXEC, so the divide-by-zero
    // decision uses exactly what the ALU is looking at.
    div_zero = (alu_sel_q == SEL_DIV) && (alu_b_q == 8'h00);

    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    tag_d        = tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_cout_d   = rsp_cout_q;
    rsp_err_d    = rsp_err_q;
    rsp_tag_d    = rsp_tag_q;
    ops_done_d   = ops_done_q;

    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Simultaneous push and pop leaves occupancy unchanged.
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          alu_a_d   = head.a;
          alu_b_d   = head.b;
          alu_sel_d = head.sel;
          tag_d     = head.tag;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // One cycle for the ALU to settle, then capture at the closing edge.
        rsp_valid_d  = 1'b1;
        rsp_result_d = div_zero ? 8'h00 : alu_out;
        rsp_cout_d   = (alu_sel_q == SEL_ADD) ? alu_cout : 1'b0;
        rsp_err_d    = div_zero;
        rsp_tag_d    = tag_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          ops_done_d  = ops_done_q + OPS_ONE;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      tag_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_tag_q    <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_cout_q   <= rsp_cout_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tag_q    <= rsp_tag_d;
      ops_done_q   <= ops_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_tag    = rsp_tag_q;
  assign ops_done   = ops_done_q;
  assign dbg_state  = state_q;

endmodule
